// File: rtl/jam_perm_sequencer.sv
// Enumerates all N! job assignments in lexicographic order and streams them to the
// cost datapath, reporting the lowest changed worker so partial sums can be reused.
module jam_perm_sequencer #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start_i,
    input  logic            perm_ready_i,
    output logic            perm_valid_o,
    output logic [N*IW-1:0] perm_o,
    output logic [IW-1:0]   change_idx_o,
    output logic            perm_last_o,
    output logic [CW-1:0]   perm_index_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [1:0]      state_o
);

    // Handshake: a permutation transfers on any rising edge where perm_valid_o and
    // perm_ready_i are both high; all perm_* outputs hold steady until that edge.
    typedef enum logic [1:0] {S_IDLE, S_OUT, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [N*IW-1:0]   perm_q, perm_d;
    logic [IW-1:0]     change_q, change_d;
    logic [CW-1:0]     index_q, index_d;

    logic [IW-1:0]     p [N];
    logic [IW-1:0]     s [N];
    logic [IW-1:0]     q [N];
    logic [IW-1:0]     pivot;
    logic [IW-1:0]     swap_pos;
    logic [N*IW-1:0]   next_perm;
    logic              is_last;

    function automatic logic [N*IW-1:0] identity_perm();
        logic [N*IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[IW*i +: IW] = IW'(i);
        return r;
    endfunction

    // Successor permutation: swap pivot with the rightmost larger entry, then
    // reverse the (descending) tail after the pivot.
    always_comb begin
        for (int i = 0; i < N; i++) p[i] = perm_q[IW*i +: IW];
        pivot = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (p[i] < p[i+1]) pivot = IW'(i);
        end
        swap_pos = '0;
        for (int j = 0; j < N; j++) begin
            if (j > int'(pivot) && p[j] > p[pivot]) swap_pos = IW'(j);
        end
        s = p;
        s[pivot]    = p[swap_pos];
        s[swap_pos] = p[pivot];
        for (int i = 0; i < N; i++) begin
            if (i > int'(pivot)) q[i] = s[N + int'(pivot) - i];
            else                 q[i] = s[i];
        end
        next_perm = '0;
        for (int i = 0; i < N; i++) next_perm[IW*i +: IW] = q[i];
    end

    always_comb begin
        is_last = 1'b1;
        for (int i = 0; i < N - 1; i++) begin
            if (!(p[i] > p[i+1])) is_last = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            perm_q   <= identity_perm();
            change_q <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            perm_q   <= perm_d;
            change_q <= change_d;
            index_q  <= index_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        perm_d   = perm_q;
        change_d = change_q;
        index_d  = index_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    perm_d   = identity_perm();
                    change_d = '0;
                    index_d  = '0;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (perm_ready_i) state_d = is_last ? S_DONE : S_CALC;
            end
            S_CALC: begin
                perm_d   = next_perm;
                change_d = pivot;
                index_d  = index_q + CW'(1);
                state_d  = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        perm_valid_o = (state_q == S_OUT);
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        perm_o       = perm_q;
        change_idx_o = change_q;
        perm_index_o = index_q;
        perm_last_o  = is_last;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_jam_perm_sequencer.sv
// Bench for jam_perm_sequencer: N=8 and N=3 instances checked against a
// factorial-number-system model of lexicographic permutation order.
module tb_jam_perm_sequencer;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        start8, ready8, valid8, last8, busy8, done8;
  logic [23:0] perm8;
  logic [2:0]  chg8;
  logic [15:0] idx8;
  logic [1:0]  st8;

  logic        start3, ready3, valid3, last3, busy3, done3;
  logic [5:0]  perm3;
  logic [1:0]  chg3;
  logic [15:0] idx3;
  logic [1:0]  st3;

  int tests = 0;
  int failed = 0;
  int done8_cnt = 0;
  int done3_cnt = 0;
  bit track = 1'b0;
  bit seen [int];

  jam_perm_sequencer #(.N(8), .IW(3), .CW(16)) dut8 (
    .CLK(CLK), .RST(RST), .start_i(start8), .perm_ready_i(ready8),
    .perm_valid_o(valid8), .perm_o(perm8), .change_idx_o(chg8),
    .perm_last_o(last8), .perm_index_o(idx8), .busy_o(busy8),
    .done_o(done8), .state_o(st8)
  );

  jam_perm_sequencer #(.N(3), .IW(2), .CW(16)) dut3 (
    .CLK(CLK), .RST(RST), .start_i(start3), .perm_ready_i(ready3),
    .perm_valid_o(valid3), .perm_o(perm3), .change_idx_o(chg3),
    .perm_last_o(last3), .perm_index_o(idx3), .busy_o(busy3),
    .done_o(done3), .state_o(st3)
  );

  always @(negedge CLK) begin
    if (done8) done8_cnt++;
    if (done3) done3_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok);
    tests++;
    if (!ok) begin
      failed++;
      $error("FAIL %s", tag);
    end
  endtask

  // Permutation number idx decoded digit by digit (factorial base).
  function automatic logic [31:0] model_perm(int nn, int iw, int idx);
    int avail[$];
    int rem;
    int f;
    int d;
    logic [31:0] r;
    rem = idx;
    r = '0;
    for (int j = 0; j < nn; j++) avail.push_back(j);
    for (int pos = 0; pos < nn; pos++) begin
      f = 1;
      for (int j = 2; j < nn - pos; j++) f *= j;
      d = rem / f;
      rem = rem % f;
      r |= 32'(avail[d]) << (iw * pos);
      avail.delete(d);
    end
    return r;
  endfunction

  function automatic int model_change(int nn, int iw, int idx);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mask;
    if (idx == 0) return 0;
    a = model_perm(nn, iw, idx - 1);
    b = model_perm(nn, iw, idx);
    mask = (32'd1 << iw) - 32'd1;
    for (int pos = 0; pos < nn; pos++) begin
      if (((a >> (iw * pos)) & mask) != ((b >> (iw * pos)) & mask)) return pos;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check8(input int idx);
    chk("p8_valid", valid8 === 1'b1);
    chk("p8_perm", 32'(perm8) === model_perm(8, 3, idx));
    chk("p8_change", 32'(chg8) === 32'(model_change(8, 3, idx)));
    chk("p8_index", idx8 === 16'(idx));
    chk("p8_last", last8 === (idx == 40319));
    chk("p8_busy", busy8 === 1'b1);
  endtask

  task automatic check3(input int idx);
    chk("p3_valid", valid3 === 1'b1);
    chk("p3_perm", 32'(perm3) === model_perm(3, 2, idx));
    chk("p3_change", 32'(chg3) === 32'(model_change(3, 2, idx)));
    chk("p3_index", idx3 === 16'(idx));
    chk("p3_last", last3 === (idx == 5));
  endtask

  // Waits (bounded) for valid, then presents random ready until an accept.
  task automatic accept8(input int idx, input int pct);
    int w;
    w = 0;
    ready8 = 1'b0;
    while (!valid8 && w < 8) begin
      tick();
      w++;
    end
    chk("p8_wait_valid", valid8 === 1'b1);
    if (!valid8) return;
    w = 0;
    while (!ready8 && w < 200) begin
      ready8 = ($urandom_range(99, 0) < pct);
      check8(idx);
      if (ready8 && track) begin
        chk("p8_unique", seen.exists(int'(perm8)) == 0);
        seen[int'(perm8)] = 1'b1;
      end
      tick();
      w++;
    end
    ready8 = 1'b0;
  endtask

  logic [5:0] lit3 [6];

  initial begin
    lit3[0] = 6'h24; lit3[1] = 6'h18; lit3[2] = 6'h21;
    lit3[3] = 6'h09; lit3[4] = 6'h12; lit3[5] = 6'h06;
    start8 = 1'b0; ready8 = 1'b0; start3 = 1'b0; ready3 = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_valid8", valid8 === 1'b0);
    chk("rst_busy8", busy8 === 1'b0);
    chk("rst_done8", done8 === 1'b0);
    chk("rst_perm8", perm8 === 24'hFAC688);
    chk("rst_chg8", chg8 === 3'd0);
    chk("rst_idx8", idx8 === 16'd0);
    chk("rst_state8", st8 === 2'd0);
    chk("rst_valid3", valid3 === 1'b0);
    chk("rst_perm3", perm3 === 6'h24);

    // N=3 complete run with ready held high
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        chk("p3_calc_gap", valid3 === 1'b0);
        tick();
      end
      check3(i);
      chk("p3_literal", perm3 === lit3[i]);
      ready3 = 1'b1; tick(); ready3 = 1'b0;
    end
    chk("p3_done", done3 === 1'b1);
    chk("p3_done_busy", busy3 === 1'b1);
    chk("p3_done_valid", valid3 === 1'b0);
    tick();
    chk("p3_idle_done", done3 === 1'b0);
    chk("p3_idle_busy", busy3 === 1'b0);
    chk("p3_idle_state", st3 === 2'd0);
    chk("p3_hold_last", perm3 === 6'h06);
    tick();
    chk("p3_done_count", done3_cnt == 1);

    // N=8: first two permutations and 2-cycle spacing
    start8 = 1'b1; tick(); start8 = 1'b0;
    check8(0);
    chk("p8_first_lit", perm8 === 24'hFAC688);
    ready8 = 1'b1; tick(); ready8 = 1'b0;
    chk("p8_calc_gap", valid8 === 1'b0);
    tick();
    check8(1);
    chk("p8_second_lit", perm8 === 24'hDEC688);
    chk("p8_second_chg", chg8 === 3'd6);

    // Backpressure: five stalled cycles, then release
    repeat (5) begin
      check8(1);
      tick();
    end
    check8(1);
    ready8 = 1'b1; tick(); ready8 = 1'b0;
    chk("p8_bp_gap", valid8 === 1'b0);
    tick();
    check8(2);

    // Start while busy: in OUT and in CALC
    start8 = 1'b1; tick(); start8 = 1'b0;
    check8(2);
    ready8 = 1'b1; tick(); ready8 = 1'b0;
    start8 = 1'b1; tick(); start8 = 1'b0;
    check8(3);

    for (int i = 3; i < 100; i++) accept8(i, 50);

    // Reset mid-enumeration
    RST = 1'b1; tick(); RST = 1'b0;
    chk("abort_valid", valid8 === 1'b0);
    chk("abort_busy", busy8 === 1'b0);
    chk("abort_done", done8 === 1'b0);
    chk("abort_idx", idx8 === 16'd0);
    chk("abort_perm", perm8 === 24'hFAC688);
    repeat (4) tick();
    chk("abort_no_done", done8_cnt == 0);
    chk("abort_idle", busy8 === 1'b0);

    // Full N=8 run from a fresh start
    start8 = 1'b1; tick(); start8 = 1'b0;
    seen.delete();
    track = 1'b1;
    for (int i = 0; i < 40320; i++) accept8(i, (i < 1000) ? 50 : 94);
    track = 1'b0;
    chk("full_done", done8 === 1'b1);
    chk("full_done_busy", busy8 === 1'b1);
    chk("full_done_valid", valid8 === 1'b0);
    chk("full_last_perm", perm8 === 24'h053977);
    chk("full_last_idx", idx8 === 16'd40319);
    chk("full_last_flag", last8 === 1'b1);
    tick();
    chk("full_idle_busy", busy8 === 1'b0);
    chk("full_idle_state", st8 === 2'd0);
    tick();
    chk("full_done_count", done8_cnt == 1);
    chk("full_unique_count", seen.num() == 40320);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jam_perm_sequencer.md
Name: jam_perm_sequencer

Overview:
- Control block for the job-assignment (JAM) cost datapath.
- Enumerates every worker→job assignment (all N! permutations of jobs 0..N-1) in lexicographic order and hands each one to the cost-summing datapath over a valid/ready handshake.
- Reports the lowest changed position with each permutation, so the datapath can reuse partial sums for positions below it.
- Signals completion with a single done pulse.

Parameters:
- N, 8: number of workers and jobs; legal range 2..8.
- IW, 3: width of one job index; must satisfy 2^IW >= N.
- CW, 16: width of perm_index; must hold N!-1.

Ports:
- CLK  input  1  clock; all logic rising-edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin enumeration; honoured only in IDLE.
- perm_ready  input  1  datapath can accept the presented permutation.
- perm_valid  output  1  perm, change_idx, perm_last and perm_index are valid.
- perm  output  N*IW  job for worker i at bits [IW*i+IW-1 : IW*i]; worker 0 is most significant in lexicographic order.
- change_idx  output  IW  lowest worker index whose job differs from the previous permutation; 0 for the first permutation.
- perm_last  output  1  presented permutation is the final one (N-1,...,1,0).
- perm_index  output  CW  ordinal of the presented permutation, starting at 0.
- busy  output  1  enumeration in progress.
- done  output  1  one-cycle pulse after the last permutation is accepted.

Behaviour:
- Reset (synchronous, RST=1 at a rising edge) sets:
  - state=IDLE
  - perm=identity (worker i → job i)
  - perm_valid=0, busy=0, done=0
  - change_idx=0, perm_index=0
- RST mid-enumeration aborts immediately: no done pulse, and the next start begins again from identity.
- States: IDLE, OUT, CALC, DONE.
- IDLE:
  - start=1 loads the identity permutation, change_idx=0 and perm_index=0, then moves to OUT.
  - perm_valid rises on the cycle after the start edge.
  - start in any other state is ignored.
- OUT:
  - perm_valid=1, busy=1.
  - All outputs are held stable until an accept (perm_valid & perm_ready at a rising edge).
  - On accept with perm_last=1: go to DONE.
  - On accept with perm_last=0: go to CALC.
- CALC (exactly one cycle, perm_valid=0):
  - Find pivot k = largest index with p[k] < p[k+1].
  - Find m = largest index > k with p[m] > p[k].
  - Swap p[k] and p[m], then reverse p[k+1..N-1].
  - Register the result into perm, set change_idx=k, increment perm_index by 1.
  - Return to OUT.
- DONE: done=1 and busy=1 for one cycle, perm_valid=0; then IDLE. perm holds N-1..0 until the next start.
- perm_last is combinational from the registered perm: 1 iff p[i] > p[i+1] for all i.
- Throughput with perm_ready held high: one permutation per 2 cycles (accept at t, CALC at t+1, next valid at t+2).
- Total accepts per run: exactly N!. The final perm_index is N!-1.
- done rises on the cycle after the final accept.
- Backpressure of any length is legal. No output changes while perm_valid=1 and perm_ready=0.
- The sequencer never issues a duplicate or skipped permutation.
- Width rules:
  - perm_index never wraps within a run: 40319 < 2^16.
  - change_idx is always in 0..N-2 after the first permutation.

Test Plan:
- N=8, reset then start, perm_ready=1:
  - First perm=24'hFAC688, change_idx=0, perm_index=0, perm_valid high on the cycle after start.
  - Second perm is 0,1,2,3,4,5,7,6 with change_idx=6, perm_index=1, presented 2 cycles after the first accept.
- N=3, perm_ready=1 → sequence 012, 021, 102, 120, 201, 210; change_idx 0,1,0,1,0,1; perm_last=1 only on 210; done pulses once, 1 cycle after the 6th accept; back to IDLE with busy=0.
- N=8 full run with random perm_ready (~50%):
  - Exactly 40320 accepts, with every permutation unique (scoreboard).
  - Last perm = 7..0 with perm_index=40319 and perm_last=1.
  - Exactly one done pulse.
- Backpressure: hold perm_ready=0 for 5 cycles while perm_valid=1 → perm, change_idx, perm_index and perm_last are unchanged each cycle; release → accept, next permutation 2 cycles later.
- Start while busy, and RST asserted after 100 accepts:
  - Extra start has no effect.
  - After RST: perm_valid=0, busy=0, done never asserted.
  - A new start restarts from identity with perm_index=0.
